sa_bfp_normalizer: RTL and testbench

SA_BFP_NORMALIZER -- requirements
Module: sa_bfp_normalizer

---
 rtl/sa_bfp_normalizer.sv | 121 ++++++++++++
 tb/tb_sa_bfp_normalizer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_bfp_normalizer.sv
// Block floating-point normalizer: buffers BLOCK_SIZE elements, then emits each one shifted left by the block's shared exponent.
// Latency: first output one cycle after the final element of a block is accepted.
// Backpressure: in_ready is low while a block drains; the drain stalls with stable outputs while out_ready is low.
module sa_bfp_normalizer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int BLOCK_SIZE = 8,
    localparam int ENC_WIDTH  = ($clog2(DATA_WIDTH) < 1) ? 1 : $clog2(DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ENC_WIDTH-1:0]  out_exp,
    output logic                  out_last
);

    localparam int                   IDX_W    = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [ENC_WIDTH-1:0] MAX_ENC  = ENC_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [ENC_WIDTH-1:0]  min_enc_q, min_enc_d;
    logic [DATA_WIDTH-1:0] mem_q [BLOCK_SIZE];

    logic                  in_acc;
    logic                  out_hs;
    logic [ENC_WIDTH-1:0]  in_lsd;

    // Number of redundant sign bits below the MSB: how far x can be shifted left without changing its value.
    function automatic logic [ENC_WIDTH-1:0] lsd(input logic [DATA_WIDTH-1:0] x);
        logic [ENC_WIDTH-1:0] cnt;
        logic                 stop;
        cnt  = '0;
        stop = 1'b0;
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            if (!stop) begin
                if (x[i] == x[DATA_WIDTH-1]) begin
                    cnt = cnt + ENC_WIDTH'(1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
        return cnt;
    endfunction

    assign in_acc = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign in_lsd = lsd(in_data);

    // State and index registers; reset discards any partial block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FILL;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            min_enc_q <= MAX_ENC;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            min_enc_q <= min_enc_d;
        end
    end

    // Element buffer; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (in_acc) begin
            mem_q[wr_idx_q] <= in_data;
        end
    end

    // Next state: fill until the last element lands, drain until the last element leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_acc && (wr_idx_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (out_hs && (rd_idx_q == LAST_IDX)) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Index and running-minimum updates; the last accepted element is folded into the exponent.
    always_comb begin
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        min_enc_d = min_enc_q;
        if (state_q == FILL) begin
            if (in_acc) begin
                wr_idx_d  = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
                min_enc_d = (in_lsd < min_enc_q) ? in_lsd : min_enc_q;
            end
        end else if (out_hs) begin
            if (rd_idx_q == LAST_IDX) begin
                wr_idx_d  = '0;
                rd_idx_d  = '0;
                min_enc_d = MAX_ENC;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs are pure functions of state so they hold steady during a stall; data/exp read as zero when idle.
    always_comb begin
        in_ready  = (state_q == FILL) && !reset;
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (rd_idx_q == LAST_IDX);
        out_data  = out_valid ? (mem_q[rd_idx_q] << min_enc_q) : '0;
        out_exp   = out_valid ? min_enc_q : '0;
    end

endmodule

// File: tb/tb_sa_bfp_normalizer.sv
// Bench for sa_bfp_normalizer with 16-bit elements in blocks of four.
// Expected outputs come from a constant vector table and are queued when a block is fed.
// Output readiness is steady, stalled or random depending on the phase of the test.
module tb_sa_bfp_normalizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_exp;
    logic        out_last;

    sa_bfp_normalizer #(.DATA_WIDTH(16), .BLOCK_SIZE(4)) dut (
        .clock    (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exp  (out_exp),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din  [4];
        logic [3:0]  exp;
        logic [15:0] dout [4];
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  e;
        logic        l;
    } exp_t;

    vec_t tbl [6];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   or_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // out_ready source: 0 = always ready, 1 = stalled, 2 = random.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: scoreboard pops, stall stability, idle zeros, in_ready behaviour.
    logic        held_vld = 1'b0;
    logic [15:0] held_d;
    logic [3:0]  held_e;
    logic        held_l;
    logic        prev_last_hs = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            held_vld     = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_last_hs) chk("in_ready_after_last", 32'(in_ready), 32'd1);
            if (held_vld) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data",  32'(out_data),  32'(held_d));
                chk("stall_exp",   32'(out_exp),   32'(held_e));
                chk("stall_last",  32'(out_last),  32'(held_l));
            end
            if (out_valid) begin
                chk("drain_in_ready", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got data %h exp %0d, expected no output", out_data, out_exp);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.d));
                        chk("out_exp",  32'(out_exp),  32'(e.e));
                        chk("out_last", 32'(out_last), 32'(e.l));
                    end
                end
            end else begin
                chk("idle_outputs", {11'd0, out_data, out_exp, out_last}, 32'd0);
            end
            held_vld     = out_valid && !out_ready;
            held_d       = out_data;
            held_e       = out_exp;
            held_l       = out_last;
            prev_last_hs = out_valid && out_ready && out_last;
        end
    end

    // Feed the first n elements of v; optionally queue its expected outputs and check first-output latency.
    task automatic feed(input vec_t v, input int n, input bit push, input bit lat);
        bit got;
        if (push) begin
            for (int k = 0; k < 4; k++) sb.push_back('{d: v.dout[k], e: v.exp, l: (k == 3)});
        end
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = v.din[k];
            got      = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got no in_ready, expected acceptance of element %0d", k);
                return;
            end
            @(posedge clk);
            #1;
        end
        if (lat && n == 4) chk("first_out_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d outputs pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{din: '{16'h0001, 16'h0100, 16'hFFF0, 16'h0000}, exp: 4'd6,
                   dout: '{16'h0040, 16'h4000, 16'hFC00, 16'h0000}};
        tbl[1] = '{din: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, exp: 4'd15,
                   dout: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        tbl[2] = '{din: '{16'h8000, 16'h0001, 16'h0002, 16'h0003}, exp: 4'd0,
                   dout: '{16'h8000, 16'h0001, 16'h0002, 16'h0003}};
        tbl[3] = '{din: '{16'h0003, 16'h0004, 16'hFFFE, 16'h0010}, exp: 4'd10,
                   dout: '{16'h0C00, 16'h1000, 16'hF800, 16'h4000}};
        tbl[4] = '{din: '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, exp: 4'd0,
                   dout: '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000}};
        tbl[5] = '{din: '{16'hFF00, 16'hFF80, 16'h00FF, 16'h0040}, exp: 4'd7,
                   dout: '{16'h8000, 16'hC000, 16'h7F80, 16'h2000}};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_exp",   32'(out_exp),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table vectors, alternating steady and random downstream readiness.
        for (int i = 0; i < 6; i++) begin
            or_mode = (i % 2) ? 2 : 0;
            feed(tbl[i], 4, 1'b1, 1'b1);
            in_valid = 1'b0;
            wait_empty();
        end
        or_mode = 0;

        // Stall at the start of a drain while upstream keeps offering data.
        or_mode = 1;
        @(posedge clk);
        #1;
        feed(tbl[0], 4, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        or_mode  = 0;
        in_valid = 1'b0;
        wait_empty();
        feed(tbl[3], 4, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_empty();

        // Reset after two elements of a block; only the next block may appear.
        feed(tbl[1], 2, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midfill_rst_in_ready",  32'(in_ready),  32'd0);
        chk("midfill_rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        feed(tbl[5], 4, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_empty();

        // Reset while a full block is waiting to drain.
        or_mode = 1;
        @(posedge clk);
        #1;
        feed(tbl[3], 4, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("middrain_rst_out_valid", 32'(out_valid), 32'd0);
        reset   = 1'b0;
        or_mode = 0;
        feed(tbl[4], 4, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_empty();

        // Back-to-back blocks with continuous valid and ready.
        feed(tbl[2], 4, 1'b1, 1'b1);
        feed(tbl[1], 4, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_empty();
        repeat (4) @(posedge clk);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
